// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap sequencer for the pipelined RV32I core.
// Handles ecall/ebreak/mret from Decode and owns mtvec/mepc/mcause.
// It also drives the redirect, stall and flush requests that the hazard unit merges.
module trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EcallD,
    input  logic        EbreakD,
    input  logic        MretD,
    input  logic [31:0] PCD,
    input  logic        StallD,
    input  logic        PCSrcE,
    input  logic        Resume,
    input  logic        CsrWE,
    input  logic [11:0] CsrWAddr,
    input  logic [31:0] CsrWData,
    input  logic [11:0] CsrRAddr,
    output logic [31:0] CsrRData,
    output logic        TrapRedirectF,
    output logic [31:0] TrapPCF,
    output logic        TrapStallF,
    output logic        TrapStallD,
    output logic        TrapFlushD,
    output logic        TrapFlushE,
    output logic        Halted
);

    localparam logic [11:0] ADDR_MTVEC  = 12'h305;
    localparam logic [11:0] ADDR_MEPC   = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRAP,
        S_HALT,
        S_RESUME,
        S_RET
    } state_t;

    state_t      state;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        accept;
    logic        take_trap;

    // A Decode event is only taken from IDLE on a right-path, non-stalled instruction.
    assign accept    = (state == S_IDLE) && !StallD && !PCSrcE;
    assign take_trap = accept && (EcallD || EbreakD);

    // Sequencer: state plus registered stall/flush/redirect flags for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            TrapRedirectF <= 1'b0;
            TrapStallF    <= 1'b0;
            TrapStallD    <= 1'b0;
            TrapFlushD    <= 1'b0;
            TrapFlushE    <= 1'b0;
            Halted        <= 1'b0;
        end else begin
            TrapRedirectF <= 1'b0;
            TrapStallF    <= 1'b0;
            TrapStallD    <= 1'b0;
            TrapFlushD    <= 1'b0;
            TrapFlushE    <= 1'b0;
            Halted        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && EbreakD) begin
                        state      <= S_HALT;
                        Halted     <= 1'b1;
                        TrapStallF <= 1'b1;
                        TrapStallD <= 1'b1;
                        TrapFlushE <= 1'b1;
                    end else if (accept && (EcallD || MretD)) begin
                        state         <= EcallD ? S_TRAP : S_RET;
                        TrapRedirectF <= 1'b1;
                        TrapFlushD    <= 1'b1;
                        TrapFlushE    <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (Resume) begin
                        state         <= S_RESUME;
                        TrapRedirectF <= 1'b1;
                        TrapFlushD    <= 1'b1;
                        TrapFlushE    <= 1'b1;
                    end else begin
                        Halted     <= 1'b1;
                        TrapStallF <= 1'b1;
                        TrapStallD <= 1'b1;
                        TrapFlushE <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Redirect target follows the registered CSRs; a same-cycle mtvec write only affects later traps.
    always_comb begin
        TrapPCF = 32'd0;
        case (state)
            S_TRAP:   TrapPCF = mtvec;
            S_RESUME: TrapPCF = mepc + 32'd4;
            S_RET:    TrapPCF = mepc;
            default:  TrapPCF = 32'd0;
        endcase
    end

    // CSR storage: a trap capture takes precedence over a software write to mepc/mcause.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtvec  <= {MTVEC_RESET[31:2], 2'b00};
            mepc   <= 32'd0;
            mcause <= 32'd0;
        end else begin
            if (CsrWE && (CsrWAddr == ADDR_MTVEC))
                mtvec <= {CsrWData[31:2], 2'b00};
            if (take_trap) begin
                mepc   <= {PCD[31:2], 2'b00};
                mcause <= EbreakD ? 32'd3 : 32'd11;
            end else begin
                if (CsrWE && (CsrWAddr == ADDR_MEPC))
                    mepc <= {CsrWData[31:2], 2'b00};
                if (CsrWE && (CsrWAddr == ADDR_MCAUSE))
                    mcause <= CsrWData;
            end
        end
    end

    // Read port has no write bypass: it always shows the current register contents.
    always_comb begin
        CsrRData = 32'd0;
        case (CsrRAddr)
            ADDR_MTVEC:  CsrRData = mtvec;
            ADDR_MEPC:   CsrRData = mepc;
            ADDR_MCAUSE: CsrRData = mcause;
            default:     CsrRData = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_trap_unit.sv
// Directed testbench for trap_unit: each task drives one scenario and checks outputs inline.
module tb_trap_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        EcallD, EbreakD, MretD;
    logic [31:0] PCD;
    logic        StallD, PCSrcE, Resume;
    logic        CsrWE;
    logic [11:0] CsrWAddr;
    logic [31:0] CsrWData;
    logic [11:0] CsrRAddr;
    logic [31:0] CsrRData;
    logic        TrapRedirectF;
    logic [31:0] TrapPCF;
    logic        TrapStallF, TrapStallD, TrapFlushD, TrapFlushE, Halted;

    logic [5:0]  flags;
    int          vectors = 0;
    int          miscompares = 0;

    // {redirect, flushD, flushE, stallF, stallD, halted}
    assign flags = {TrapRedirectF, TrapFlushD, TrapFlushE, TrapStallF, TrapStallD, Halted};

    localparam logic [5:0] F_NONE  = 6'b000000;
    localparam logic [5:0] F_REDIR = 6'b111000;
    localparam logic [5:0] F_HALT  = 6'b001111;

    trap_unit #(.MTVEC_RESET(32'h0000_0100)) dut (
        .clk(clk), .reset(reset),
        .EcallD(EcallD), .EbreakD(EbreakD), .MretD(MretD), .PCD(PCD),
        .StallD(StallD), .PCSrcE(PCSrcE), .Resume(Resume),
        .CsrWE(CsrWE), .CsrWAddr(CsrWAddr), .CsrWData(CsrWData),
        .CsrRAddr(CsrRAddr), .CsrRData(CsrRData),
        .TrapRedirectF(TrapRedirectF), .TrapPCF(TrapPCF),
        .TrapStallF(TrapStallF), .TrapStallD(TrapStallD),
        .TrapFlushD(TrapFlushD), .TrapFlushE(TrapFlushE), .Halted(Halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        CsrRAddr = a;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if (flags !== F_NONE) begin miscompares++; $display("FAIL reset_flags got %b want %b", flags, F_NONE); end
        vectors++;
        if (TrapPCF !== 32'd0) begin miscompares++; $display("FAIL reset_pc got %h want 0", TrapPCF); end
        rd(12'h305);
        vectors++;
        if (CsrRData !== 32'h100) begin miscompares++; $display("FAIL reset_mtvec got %h want 100", CsrRData); end
        rd(12'h341);
        vectors++;
        if (CsrRData !== 32'h0) begin miscompares++; $display("FAIL reset_mepc got %h want 0", CsrRData); end
        rd(12'h342);
        vectors++;
        if (CsrRData !== 32'h0) begin miscompares++; $display("FAIL reset_mcause got %h want 0", CsrRData); end
    endtask

    task automatic test_ecall();
        EcallD = 1'b1; PCD = 32'h40;
        tick();
        EcallD = 1'b0;
        vectors++;
        if (flags !== F_REDIR) begin miscompares++; $display("FAIL ecall_flags got %b want %b", flags, F_REDIR); end
        vectors++;
        if (TrapPCF !== 32'h100) begin miscompares++; $display("FAIL ecall_pc got %h want 100", TrapPCF); end
        tick();
        vectors++;
        if (flags !== F_NONE) begin miscompares++; $display("FAIL ecall_oneshot got %b want %b", flags, F_NONE); end
        rd(12'h341);
        vectors++;
        if (CsrRData !== 32'h40) begin miscompares++; $display("FAIL ecall_mepc got %h want 40", CsrRData); end
        rd(12'h342);
        vectors++;
        if (CsrRData !== 32'd11) begin miscompares++; $display("FAIL ecall_mcause got %0d want 11", CsrRData); end
    endtask

    task automatic test_blocked();
        EcallD = 1'b1; PCD = 32'h60; PCSrcE = 1'b1;
        tick();
        EcallD = 1'b0; PCSrcE = 1'b0;
        vectors++;
        if (flags !== F_NONE) begin miscompares++; $display("FAIL wrongpath_flags got %b want %b", flags, F_NONE); end
        rd(12'h341);
        vectors++;
        if (CsrRData !== 32'h40) begin miscompares++; $display("FAIL wrongpath_mepc got %h want 40", CsrRData); end
        EcallD = 1'b1; PCD = 32'h70; StallD = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (flags !== F_NONE) begin miscompares++; $display("FAIL stalled_flags cycle %0d got %b want %b", i, flags, F_NONE); end
        end
        StallD = 1'b0;
        tick();
        EcallD = 1'b0;
        vectors++;
        if (flags !== F_REDIR) begin miscompares++; $display("FAIL unstalled_flags got %b want %b", flags, F_REDIR); end
        tick();
        rd(12'h341);
        vectors++;
        if (CsrRData !== 32'h70) begin miscompares++; $display("FAIL unstalled_mepc got %h want 70", CsrRData); end
    endtask

    task automatic test_ebreak();
        EbreakD = 1'b1; PCD = 32'h80;
        tick();
        EbreakD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (flags !== F_HALT) begin miscompares++; $display("FAIL halt_flags cycle %0d got %b want %b", i, flags, F_HALT); end
            if (i == 4) Resume = 1'b1;
            tick();
        end
        Resume = 1'b0;
        vectors++;
        if (flags !== F_REDIR) begin miscompares++; $display("FAIL resume_flags got %b want %b", flags, F_REDIR); end
        vectors++;
        if (TrapPCF !== 32'h84) begin miscompares++; $display("FAIL resume_pc got %h want 84", TrapPCF); end
        rd(12'h342);
        vectors++;
        if (CsrRData !== 32'd3) begin miscompares++; $display("FAIL ebreak_mcause got %0d want 3", CsrRData); end
        tick();
        vectors++;
        if (flags !== F_NONE) begin miscompares++; $display("FAIL resume_oneshot got %b want %b", flags, F_NONE); end
        Resume = 1'b1;
        tick();
        Resume = 1'b0;
        vectors++;
        if (flags !== F_NONE) begin miscompares++; $display("FAIL stray_resume got %b want %b", flags, F_NONE); end
    endtask

    task automatic test_priority_wrap();
        EbreakD = 1'b1; EcallD = 1'b1; MretD = 1'b1; PCD = 32'hFFFF_FFFC;
        tick();
        EbreakD = 1'b0; EcallD = 1'b0; MretD = 1'b0;
        vectors++;
        if (flags !== F_HALT) begin miscompares++; $display("FAIL prio_flags got %b want %b", flags, F_HALT); end
        Resume = 1'b1;
        tick();
        Resume = 1'b0;
        vectors++;
        if (TrapPCF !== 32'h0) begin miscompares++; $display("FAIL wrap_pc got %h want 0", TrapPCF); end
        tick();
    endtask

    task automatic test_csr();
        CsrWE = 1'b1; CsrWAddr = 12'h305; CsrWData = 32'h203;
        rd(12'h305);
        vectors++;
        if (CsrRData !== 32'h100) begin miscompares++; $display("FAIL no_bypass got %h want 100", CsrRData); end
        tick();
        CsrWE = 1'b0;
        rd(12'h305);
        vectors++;
        if (CsrRData !== 32'h200) begin miscompares++; $display("FAIL mtvec_mask got %h want 200", CsrRData); end
        rd(12'h300);
        vectors++;
        if (CsrRData !== 32'h0) begin miscompares++; $display("FAIL unmapped_read got %h want 0", CsrRData); end
        EcallD = 1'b1; PCD = 32'h40;
        CsrWE = 1'b1; CsrWAddr = 12'h341; CsrWData = 32'h999;
        tick();
        EcallD = 1'b0;
        vectors++;
        if (TrapPCF !== 32'h200) begin miscompares++; $display("FAIL new_mtvec_pc got %h want 200", TrapPCF); end
        CsrWAddr = 12'h305; CsrWData = 32'h300;
        tick();
        CsrWE = 1'b0;
        rd(12'h341);
        vectors++;
        if (CsrRData !== 32'h40) begin miscompares++; $display("FAIL capture_wins got %h want 40", CsrRData); end
        rd(12'h305);
        vectors++;
        if (CsrRData !== 32'h300) begin miscompares++; $display("FAIL trap_cycle_mtvec got %h want 300", CsrRData); end
    endtask

    task automatic test_mret();
        CsrWE = 1'b1; CsrWAddr = 12'h341; CsrWData = 32'h47;
        tick();
        CsrWE = 1'b0;
        MretD = 1'b1;
        tick();
        MretD = 1'b0;
        vectors++;
        if (flags !== F_REDIR) begin miscompares++; $display("FAIL mret_flags got %b want %b", flags, F_REDIR); end
        vectors++;
        if (TrapPCF !== 32'h44) begin miscompares++; $display("FAIL mret_pc got %h want 44", TrapPCF); end
        tick();
        vectors++;
        if (flags !== F_NONE) begin miscompares++; $display("FAIL mret_oneshot got %b want %b", flags, F_NONE); end
        rd(12'h342);
        vectors++;
        if (CsrRData !== 32'd11) begin miscompares++; $display("FAIL mret_mcause got %0d want 11", CsrRData); end
    endtask

    task automatic test_reset_in_halt();
        EbreakD = 1'b1; PCD = 32'h88;
        tick();
        EbreakD = 1'b0;
        vectors++;
        if (flags !== F_HALT) begin miscompares++; $display("FAIL prereset_halt got %b want %b", flags, F_HALT); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (flags !== F_NONE) begin miscompares++; $display("FAIL halt_reset_flags got %b want %b", flags, F_NONE); end
        rd(12'h305);
        vectors++;
        if (CsrRData !== 32'h100) begin miscompares++; $display("FAIL halt_reset_mtvec got %h want 100", CsrRData); end
        rd(12'h341);
        vectors++;
        if (CsrRData !== 32'h0) begin miscompares++; $display("FAIL halt_reset_mepc got %h want 0", CsrRData); end
        EcallD = 1'b1; PCD = 32'h20;
        tick();
        EcallD = 1'b0;
        vectors++;
        if (flags !== F_REDIR) begin miscompares++; $display("FAIL post_reset_ecall got %b want %b", flags, F_REDIR); end
        vectors++;
        if (TrapPCF !== 32'h100) begin miscompares++; $display("FAIL post_reset_pc got %h want 100", TrapPCF); end
        tick();
    endtask

    initial begin
        reset = 1'b1; EcallD = 1'b0; EbreakD = 1'b0; MretD = 1'b0; PCD = 32'd0;
        StallD = 1'b0; PCSrcE = 1'b0; Resume = 1'b0;
        CsrWE = 1'b0; CsrWAddr = 12'd0; CsrWData = 32'd0; CsrRAddr = 12'd0;
        test_reset();
        test_ecall();
        test_blocked();
        test_ebreak();
        test_priority_wrap();
        test_csr();
        test_mret();
        test_reset_in_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trap_unit.md
# trap_unit

Machine-mode trap sequencer for the pipelined RV32I core.
- Consumes the Decode-stage `Ecall`/`Ebreak` flags produced by the controller, plus an `mret` flag.
- Captures `mepc`/`mcause` and redirects fetch to `mtvec`.
- Halts the pipeline on `ebreak` until a resume pulse arrives.
- Owns the three trap CSRs and drives the redirect/stall/flush requests merged by the hazard unit.

## Interface
Parameters:
- `MTVEC_RESET`, default `32'h0000_0100`: reset value of `mtvec`. Bits [1:0] are ignored (always direct mode).

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `EcallD`  in  1  `ecall` decoded in Decode.
- `EbreakD`  in  1  `ebreak` decoded in Decode.
- `MretD`  in  1  `mret` decoded in Decode.
- `PCD`  in  32  PC of the Decode-stage instruction.
- `StallD`  in  1  Decode stall from the hazard unit.
- `PCSrcE`  in  1  branch/jump taken in Execute; the Decode instruction is on the wrong path.
- `Resume`  in  1  debug resume pulse; only meaningful in HALT.
- `CsrWE`  in  1  CSR write enable (from Writeback).
- `CsrWAddr`  in  12  CSR write address.
- `CsrWData`  in  32  CSR write data.
- `CsrRAddr`  in  12  CSR read address.
- `CsrRData`  out  32  combinational read data.
- `TrapRedirectF`  out  1  overrides the next PC with `TrapPCF`.
- `TrapPCF`  out  32  redirect target.
- `TrapStallF`  out  1  stall request for the Fetch register.
- `TrapStallD`  out  1  stall request for the Decode register.
- `TrapFlushD`  out  1  flush request for the Decode register.
- `TrapFlushE`  out  1  flush request for the Execute register.
- `Halted`  out  1  core halted on `ebreak`.

## Operation
CSRs:
- `mtvec` (0x305): bits [1:0] are forced to 0 on write.
- `mepc` (0x341): bits [1:0] are forced to 0.
- `mcause` (0x342): full 32-bit register.
- Reads of any other address return 0. Writes to any other address are dropped.
- Reset values: `mtvec`=`MTVEC_RESET` with [1:0]=0; `mepc`=0; `mcause`=0.

Event acceptance:
- An event is accepted only when state=IDLE, `StallD`=0 and `PCSrcE`=0.
- If more than one flag is high, priority is Ebreak > Ecall > Mret.
- Events are ignored in every other state. An event whose acceptance is blocked by `StallD` is accepted on the first cycle the conditions hold; this is not a separate pending state.

State machine (IDLE, TRAP, HALT, RESUME, RET):
- IDLE, accepted Ecall: `mepc`<=`PCD`, `mcause`<=11, go to TRAP.
- IDLE, accepted Ebreak: `mepc`<=`PCD`, `mcause`<=3, go to HALT.
- IDLE, accepted Mret: go to RET. CSRs are unchanged.
- TRAP: `TrapRedirectF`=1, `TrapPCF`=`mtvec`, `TrapFlushD`=1, `TrapFlushE`=1. Go to IDLE next cycle.
- HALT: `Halted`=1, `TrapStallF`=1, `TrapStallD`=1, `TrapFlushE`=1. Stay until `Resume`=1, then go to RESUME.
- RESUME: redirect to `mepc`+4 (32-bit wrap), flush D and E. Go to IDLE.
- RET: redirect to `mepc`, flush D and E. Go to IDLE.

Simultaneous events:
- If a CSR write to `mepc`/`mcause` lands in the same cycle as an accepted trap capture, the trap capture wins.
- A CSR write to `mtvec` in the TRAP cycle affects only later traps. `TrapPCF` uses the registered `mtvec` value.

Reset:
- Any state goes to IDLE. All outputs are 0 in the cycle after `reset` is sampled high.
- Combinational outputs are gated by state, so they are 0 while in IDLE.

## Timing
- Event in Decode at cycle T: the CSR capture and state change happen at edge T+1.
- Redirect and flush are asserted during cycle T+1, for exactly 1 cycle. The handler's first instruction enters Fetch at edge T+2.
- HALT stalls start in cycle T+1. The `ebreak` itself is in Execute at T+1 and is bubbled by `TrapFlushE`.
- `Resume` seen at cycle R: the RESUME redirect happens in cycle R+1. `Halted` drops in cycle R+1.
- A `Resume` pulse outside HALT has no effect.
- `CsrRData` is combinational from `CsrRAddr` and the current register values. There is no write-to-read bypass: a read in the same cycle as a write returns the old value.
- No output depends combinationally on `EcallD`, `EbreakD` or `MretD`.

## Test plan
- Ecall at `PCD`=0x40, reset `mtvec`: in cycle T+1, `TrapRedirectF`=1, `TrapPCF`=0x100, `TrapFlushD`=`TrapFlushE`=1 for exactly one cycle. Afterwards `mepc`=0x40, `mcause`=11, and state returns to IDLE.
- Ecall with `PCSrcE`=1: no redirect, CSRs unchanged. Ecall held with `StallD`=1 for 2 cycles then 0: accepted only at the third cycle, redirect one cycle later.
- Ebreak at 0x80, `Resume` pulsed 5 cycles later: `Halted` and the stalls are high for 5 cycles, `mcause`=3. Then a single redirect to 0x84, and `Halted`=0.
- Write 0x203 to 0x305: a read returns 0x200 and a later Ecall redirects to 0x200. A `mepc` write of 0x999 in the same cycle as an Ecall capture at 0x40 leaves `mepc`=0x40. A read of 0x300 returns 0.
- Write `mepc`=0x44, then Mret: one-cycle redirect to 0x44 with D/E flush, `mcause` unchanged.
- `reset` asserted while in HALT: the next cycle `Halted`, the stalls and the redirect are 0, `mtvec`=0x100, `mepc`=0, and an Ecall is accepted normally afterwards.
